// File: rtl/operand_fetch.sv
// Operand fetch stage: a 2-read/1-write register file with register 0 tied
// to zero, a 4-bit flag register, and a single-entry output register that
// carries {A, B, opcode, carry} to the ALU under valid/ready handshaking.
// Same-cycle register and flag writebacks are forwarded into the captured
// bundle, so an issue never sees a value that is about to be overwritten.
module operand_fetch #(
    parameter int DATA_W  = 64,
    parameter int REG_CNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_fsec,
    input  logic [4:0]        in_ra,
    input  logic [4:0]        in_rb,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_flags_en,
    input  logic [3:0]        wb_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [4:0]        out_fsec,
    output logic              out_carry,
    output logic [3:0]        flags
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [3:0]        flags_q;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_a_q, out_a_d;
    logic [DATA_W-1:0] out_b_q, out_b_d;
    logic [4:0]        out_fsec_q, out_fsec_d;
    logic              out_carry_q, out_carry_d;

    logic [DATA_W-1:0] opa_s;
    logic [DATA_W-1:0] rfb_s;
    logic              carry_s;
    logic              capture_s;

    // Accept a new issue when the output slot is empty or being drained this cycle.
    always_comb begin
        in_ready  = !out_valid_q || out_ready;
        capture_s = in_valid && in_ready;
    end

    // Operand reads with register-0 masking and same-cycle writeback forwarding.
    always_comb begin
        opa_s   = {DATA_W{1'b0}};
        rfb_s   = {DATA_W{1'b0}};
        carry_s = 1'b0;
        if (in_ra == 5'd0) begin
            opa_s = {DATA_W{1'b0}};
        end else if (wb_en && (wb_addr == in_ra)) begin
            opa_s = wb_data;
        end else begin
            opa_s = regs_q[in_ra];
        end
        if (in_rb == 5'd0) begin
            rfb_s = {DATA_W{1'b0}};
        end else if (wb_en && (wb_addr == in_rb)) begin
            rfb_s = wb_data;
        end else begin
            rfb_s = regs_q[in_rb];
        end
        if (wb_flags_en) begin
            carry_s = wb_flags[2];
        end else begin
            carry_s = flags_q[2];
        end
    end

    // Next state of the output slot: load on capture, clear on drain, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_fsec_d  = out_fsec_q;
        out_carry_d = out_carry_q;
        if (capture_s) begin
            out_valid_d = 1'b1;
            out_a_d     = opa_s;
            out_b_d     = in_use_imm ? in_imm : rfb_s;
            out_fsec_d  = in_fsec;
            out_carry_d = carry_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Register file write port; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Flag register and output slot state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q     <= 4'd0;
            out_valid_q <= 1'b0;
            out_a_q     <= {DATA_W{1'b0}};
            out_b_q     <= {DATA_W{1'b0}};
            out_fsec_q  <= 5'd0;
            out_carry_q <= 1'b0;
        end else begin
            if (wb_flags_en) begin
                flags_q <= wb_flags;
            end
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_fsec_q  <= out_fsec_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_fsec  = out_fsec_q;
    assign out_carry = out_carry_q;
    assign flags     = flags_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_W, default 64, operand and register width.
REQ-002 Parameter REG_CNT, default 32, number of architectural registers; address width 5.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  issue request valid.
REQ-006 in_ready  output  1  stage can accept an issue request this cycle.
REQ-007 in_fsec  input  5  ALU opcode to forward.
REQ-008 in_ra  input  5  register address for operand A.
REQ-009 in_rb  input  5  register address for operand B.
REQ-010 in_use_imm  input  1  1 = operand B taken from in_imm instead of register file.
REQ-011 in_imm  input  64  immediate value for operand B.
REQ-012 wb_en  input  1  register write enable.
REQ-013 wb_addr  input  5  register write address.
REQ-014 wb_data  input  64  register write data.
REQ-015 wb_flags_en  input  1  flag register write enable.
REQ-016 wb_flags  input  4  ALU signal bits {signed overflow, unsigned carry, negative, zero}.
REQ-017 out_valid  output  1  operand bundle valid toward ALU.
REQ-018 out_ready  input  1  downstream accepts bundle this cycle.
REQ-019 out_a  output  64  ALU operand A.
REQ-020 out_b  output  64  ALU operand B.
REQ-021 out_fsec  output  5  ALU opcode.
REQ-022 out_carry  output  1  ALU carry input.
REQ-023 flags  output  4  current flag register contents.

Function
REQ-024 Register file: REG_CNT x DATA_W, two combinational read ports (ra, rb), one synchronous write port.
REQ-025 Register 0 shall read as zero always; writes with wb_addr = 0 ignored.
REQ-026 Write: on rising edge with wb_en = 1 and wb_addr != 0, reg[wb_addr] <= wb_data.
REQ-027 Flag register: on rising edge with wb_flags_en = 1, flags <= wb_flags; otherwise holds.
REQ-028 Output register is a single-entry pipeline stage; in_ready = !out_valid || out_ready (combinational).
REQ-029 Capture: when in_valid && in_ready, on the edge out_valid <= 1 and out_a/out_b/out_fsec/out_carry load; latency exactly 1 cycle.
REQ-030 out_a = value of reg[in_ra]; out_b = in_use_imm ? in_imm : reg[in_rb]; out_fsec = in_fsec; out_carry = flags[2].
REQ-031 Write bypass: if capture and a register write to the same nonzero address occur in the same cycle, captured operand shall be wb_data, not the stale register value.
REQ-032 Flag bypass: if capture and wb_flags_en coincide, out_carry shall be wb_flags[2].
REQ-033 Bypass applies independently to A and B; ra = rb = wb_addr gives wb_data on both.
REQ-034 Drain: out_valid && out_ready with no new capture -> out_valid <= 0 next edge.
REQ-035 Back-to-back: out_valid && out_ready && in_valid -> new bundle loaded, out_valid stays 1, one issue per cycle.
REQ-036 Stall: out_valid && !out_ready -> in_ready = 0, all out_* held bit-stable, register/flag writes still performed.
REQ-037 in_valid with in_ready = 0 shall not alter outputs; requester holds request.
REQ-038 No combinational path from in_valid to out_valid.

Reset
REQ-039 rst = 1 shall immediately (asynchronously) clear out_valid, out_a, out_b, out_fsec, out_carry, flags and all registers to 0.
REQ-040 Reset mid-stall discards the held bundle; no writes or captures occur while rst = 1.
REQ-041 After rst deasserts, in_ready = 1 in the first cycle.

Verification
REQ-042 Write reg5 = 0x1234, reg6 = 0x10; issue ra=5, rb=6, fsec=00010 -> next cycle out_valid=1, out_a=0x1234, out_b=0x10, out_fsec=00010.
REQ-043 Same-cycle wb_en, wb_addr=7, wb_data=0xAA with issue ra=7, rb=7 -> out_a = out_b = 0xAA; wb_addr=0, wb_data=0xFF then read ra=0 -> out_a=0.
REQ-044 wb_flags_en with wb_flags=4'b0100 in same cycle as issue fsec=00011 -> out_carry=1; flags=0100 afterward.
REQ-045 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> queued request captured next edge, no bundle lost or duplicated.
REQ-046 rst pulsed during stall with out_valid=1, out_a=0x1234 -> out_valid=0, out_a=0, flags=0, reg5 reads 0 after release.
